execute_stage: RTL and testbench

EX stage of the five-stage MIPS pipeline. It sits directly downstream of instruction decode and consumes the ID/EX control and data fields that decode produces. It performs ALU and branch-target computation and registers results into the EX/MEM pipeline latch for the memory stage. An optional iterative signed multiplier with HI/LO registers stalls upstream while it runs.

---
 rtl/execute_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_execute_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage of the five-stage MIPS pipeline: ALU, branch target and the EX/MEM latch.
// Define EX_MULT_EN to build the iterative signed multiplier with HI/LO and mfhi/mflo.
module execute_stage #(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ID_EX_wb_ctl,
  input  logic [2:0]  ID_EX_m_ctl,
  input  logic [3:0]  ID_EX_ex_ctl,
  input  logic [31:0] ID_EX_npc,
  input  logic [31:0] ID_EX_readdat1,
  input  logic [31:0] ID_EX_readdat2,
  input  logic [31:0] ID_EX_sign_ext,
  input  logic [4:0]  ID_EX_instr_20_16,
  input  logic [4:0]  ID_EX_instr_15_11,
  output logic        ex_stall,
  output logic [1:0]  EX_MEM_wb_ctl,
  output logic [2:0]  EX_MEM_m_ctl,
  output logic [31:0] EX_MEM_npc,
  output logic        EX_MEM_zero,
  output logic [31:0] EX_MEM_alu_result,
  output logic [31:0] EX_MEM_rdata2,
  output logic [4:0]  EX_MEM_write_reg
);

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMflo = 6'b010010;

  logic        reg_dst, alu_src;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b, alu_res, br_target;
  logic [4:0]  write_reg;
  logic        is_mult;
  logic        stall;

  assign reg_dst   = ID_EX_ex_ctl[3];
  assign alu_op    = ID_EX_ex_ctl[2:1];
  assign alu_src   = ID_EX_ex_ctl[0];
  assign funct     = ID_EX_sign_ext[5:0];
  assign op_a      = ID_EX_readdat1;
  assign op_b      = alu_src ? ID_EX_sign_ext : ID_EX_readdat2;
  assign write_reg = reg_dst ? ID_EX_instr_15_11 : ID_EX_instr_20_16;
  assign br_target = ID_EX_npc + {ID_EX_sign_ext[29:0], 2'b00};

`ifdef EX_MULT_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} mult_state_e;
  localparam int unsigned CntW = $clog2(MULT_CYCLES + 1);

  mult_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d, mcand_q, mcand_d;
  logic [31:0]     mplier_q, mplier_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            neg_q, neg_d;
  logic [63:0]     signed_prod;

  assign is_mult = (alu_op == 2'b10) && (funct == FnMult);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (is_mult) state_d = StBusy;
      StBusy:  if (cnt_q == CntW'(MULT_CYCLES - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stall is gated by reset so it drops the moment reset is asserted.
  always_comb begin
    stall = rst_n && ((state_q == StBusy) || ((state_q == StIdle) && is_mult));
  end

  // Shift-add datapath on operand magnitudes; sign applied once in DONE.
  assign signed_prod = neg_q ? (~acc_q + 64'd1) : acc_q;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (is_mult) begin
          mcand_d  = {32'd0, op_a[31] ? (~op_a + 32'd1) : op_a};
          mplier_d = ID_EX_readdat2[31] ? (~ID_EX_readdat2 + 32'd1) : ID_EX_readdat2;
          neg_d    = op_a[31] ^ ID_EX_readdat2[31];
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StBusy: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + CntW'(1);
      end
      StDone: begin
        hi_d = signed_prod[63:32];
        lo_d = signed_prod[31:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
`else
  logic unused_mult_cycles;
  assign unused_mult_cycles = (MULT_CYCLES == 0);
  assign is_mult = 1'b0;
  assign stall   = 1'b0;
`endif

  assign ex_stall = stall;

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (funct)
          FnAdd:   alu_res = op_a + op_b;
          FnSub:   alu_res = op_a - op_b;
          FnAnd:   alu_res = op_a & op_b;
          FnOr:    alu_res = op_a | op_b;
          FnSlt:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
`ifdef EX_MULT_EN
          FnMfhi:  alu_res = hi_q;
          FnMflo:  alu_res = lo_q;
`endif
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  logic [1:0]  wb_q, wb_d;
  logic [2:0]  m_q, m_d;
  logic [31:0] npc_q, npc_d, res_q, res_d, rdata2_q, rdata2_d;
  logic        zero_q, zero_d;
  logic [4:0]  wreg_q, wreg_d;

  // Stalled cycles insert a bubble and keep the data fields; mult never writes a GPR.
  always_comb begin
    wb_d     = ID_EX_wb_ctl;
    m_d      = ID_EX_m_ctl;
    npc_d    = br_target;
    zero_d   = (alu_res == 32'd0);
    res_d    = alu_res;
    rdata2_d = ID_EX_readdat2;
    wreg_d   = write_reg;
    if (stall) begin
      wb_d     = '0;
      m_d      = '0;
      npc_d    = npc_q;
      zero_d   = zero_q;
      res_d    = res_q;
      rdata2_d = rdata2_q;
      wreg_d   = wreg_q;
    end else if (is_mult) begin
      wb_d = '0;
      m_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q     <= '0;
      m_q      <= '0;
      npc_q    <= '0;
      zero_q   <= 1'b0;
      res_q    <= '0;
      rdata2_q <= '0;
      wreg_q   <= '0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      npc_q    <= npc_d;
      zero_q   <= zero_d;
      res_q    <= res_d;
      rdata2_q <= rdata2_d;
      wreg_q   <= wreg_d;
    end
  end

  assign EX_MEM_wb_ctl     = wb_q;
  assign EX_MEM_m_ctl      = m_q;
  assign EX_MEM_npc        = npc_q;
  assign EX_MEM_zero       = zero_q;
  assign EX_MEM_alu_result = res_q;
  assign EX_MEM_rdata2     = rdata2_q;
  assign EX_MEM_write_reg  = wreg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: per-cycle reference model plus directed literal checks.
module tb_execute_stage;

  localparam int unsigned MultCycles = 32;
`ifdef EX_MULT_EN
  localparam bit MultEn = 1'b1;
`else
  localparam bit MultEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb;
  logic [2:0]  mc;
  logic [3:0]  ex;
  logic [31:0] npc, rd1, rd2, se;
  logic [4:0]  rt, rd;
  logic        ex_stall;
  logic [1:0]  o_wb;
  logic [2:0]  o_m;
  logic [31:0] o_npc, o_res, o_rd2;
  logic        o_zero;
  logic [4:0]  o_wreg;

  execute_stage #(.MULT_CYCLES(MultCycles)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ID_EX_wb_ctl      (wb),
    .ID_EX_m_ctl       (mc),
    .ID_EX_ex_ctl      (ex),
    .ID_EX_npc         (npc),
    .ID_EX_readdat1    (rd1),
    .ID_EX_readdat2    (rd2),
    .ID_EX_sign_ext    (se),
    .ID_EX_instr_20_16 (rt),
    .ID_EX_instr_15_11 (rd),
    .ex_stall          (ex_stall),
    .EX_MEM_wb_ctl     (o_wb),
    .EX_MEM_m_ctl      (o_m),
    .EX_MEM_npc        (o_npc),
    .EX_MEM_zero       (o_zero),
    .EX_MEM_alu_result (o_res),
    .EX_MEM_rdata2     (o_rd2),
    .EX_MEM_write_reg  (o_wreg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] npc;
    logic        zero;
    logic [31:0] res;
    logic [31:0] rd2;
    logic [4:0]  wreg;
  } exmem_t;

  exmem_t      exp_q;
  logic [31:0] m_hi, m_lo;
  int          m_cnt;  // consecutive cycles the current mult has been presented

  function automatic logic mult_in();
    return MultEn && (ex[2:1] == 2'b10) && (se[5:0] == 6'd24);
  endfunction

  function automatic logic exp_stall();
    return rst_n && mult_in() && (m_cnt <= int'(MultCycles));
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] b;
    b = ex[0] ? se : rd2;
    case (ex[2:1])
      2'd0: return rd1 + b;
      2'd1: return rd1 - b;
      2'd2: begin
        case (se[5:0])
          6'd32: return rd1 + b;
          6'd34: return rd1 - b;
          6'd36: return rd1 & b;
          6'd37: return rd1 | b;
          6'd42: return ($signed(rd1) < $signed(b)) ? 32'd1 : 32'd0;
          6'd16: return MultEn ? m_hi : 32'd0;
          6'd18: return MultEn ? m_lo : 32'd0;
          default: return 32'd0;
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      m_hi  <= '0;
      m_lo  <= '0;
      m_cnt <= 0;
    end else if (exp_stall()) begin
      exp_q.wb <= '0;
      exp_q.m  <= '0;
      m_cnt    <= m_cnt + 1;
    end else begin
      exp_q.wb   <= mult_in() ? 2'b00 : wb;
      exp_q.m    <= mult_in() ? 3'b000 : mc;
      exp_q.npc  <= npc + (se << 2);
      exp_q.zero <= (ref_result() == 32'd0);
      exp_q.res  <= ref_result();
      exp_q.rd2  <= rd2;
      exp_q.wreg <= ex[3] ? rd : rt;
      if (mult_in()) {m_hi, m_lo} <= smul(rd1, rd2);
      m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    check("ex_stall", 32'(ex_stall), 32'(exp_stall()));
    check("wb_ctl", 32'(o_wb), 32'(exp_q.wb));
    check("m_ctl", 32'(o_m), 32'(exp_q.m));
    check("npc", o_npc, exp_q.npc);
    check("zero", 32'(o_zero), 32'(exp_q.zero));
    check("alu_result", o_res, exp_q.res);
    check("rdata2", o_rd2, exp_q.rd2);
    check("write_reg", 32'(o_wreg), 32'(exp_q.wreg));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [1:0] w, input logic [2:0] m, input logic [3:0] e,
                       input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic [4:0] t, input logic [4:0] d);
    wb = w; mc = m; ex = e; npc = n; rd1 = a; rd2 = b; se = s; rt = t; rd = d;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"}, 32'(ex_stall), 32'd0);
    check({tag, " wb"}, 32'(o_wb), 32'd0);
    check({tag, " m"}, 32'(o_m), 32'd0);
    check({tag, " npc"}, o_npc, 32'd0);
    check({tag, " zero"}, 32'(o_zero), 32'd0);
    check({tag, " res"}, o_res, 32'd0);
    check({tag, " rd2"}, o_rd2, 32'd0);
    check({tag, " wreg"}, 32'(o_wreg), 32'd0);
  endtask

  int n;

  initial begin
    rst_n = 1'b1;
    drive(2'b00, 3'b000, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    #4 rst_n = 1'b1;
    step();

    // R-type add
    drive(2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd3, 5'd9);
    step();
    check("add res", o_res, 32'd12);
    check("add wreg", 32'(o_wreg), 32'd9);
    check("add zero", 32'(o_zero), 32'd0);
    check("add wb", 32'(o_wb), 32'd2);

    // beq taken
    drive(2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234, 32'h1234, 32'd3, 5'd1, 5'd2);
    step();
    check("beq zero", 32'(o_zero), 32'd1);
    check("beq npc", o_npc, 32'h10C);
    check("beq m", 32'(o_m), 32'd4);

    // lw with negative offset
    drive(2'b11, 3'b010, 4'b0001, 32'h200, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd7, 5'd8);
    step();
    check("lw res", o_res, 32'hFFC);
    check("lw wreg", 32'(o_wreg), 32'd7);
    check("lw rdata2", o_rd2, 32'hDEAD);

    // slt signed both ways
    drive(2'b10, 3'b000, 4'b1100, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd4, 5'd5);
    step();
    check("slt neg<1", o_res, 32'd1);
    drive(2'b10, 3'b000, 4'b1100, 32'h8, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd4, 5'd5);
    step();
    check("slt 1<neg", o_res, 32'd0);
    check("slt zero", 32'(o_zero), 32'd1);

    // sub/and/or, alu_op 11, unknown funct, sw
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd5, 32'h22, 5'd1, 5'd6);
    step();
    check("sub res", o_res, 32'hFFFFFFFE);
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd6);
    step();
    check("and res", o_res, 32'hF000);
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0F0, 32'hFF00, 32'h25, 5'd1, 5'd6);
    step();
    check("or res", o_res, 32'hFFF0);
    drive(2'b10, 3'b000, 4'b1110, 32'h0, 32'd9, 32'd9, 32'h20, 5'd1, 5'd6);
    step();
    check("aluop11 res", o_res, 32'd0);
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd9, 32'd9, 32'h3F, 5'd1, 5'd6);
    step();
    check("badfunct res", o_res, 32'd0);
    drive(2'b00, 3'b001, 4'b0001, 32'h40, 32'h2000, 32'hCAFE, 32'h8, 5'd10, 5'd11);
    step();
    check("sw res", o_res, 32'h2008);
    check("sw m", 32'(o_m), 32'd1);

`ifdef EX_MULT_EN
    // -3 * 7
    drive(2'b10, 3'b000, 4'b1100, 32'h50, 32'hFFFFFFFD, 32'd7, 32'h18, 5'd2, 5'd3);
    n = 0;
    #1;
    while (ex_stall === 1'b1 && n < 100) begin
      n++;
      step();
      #1;
    end
    check("mult stall cycles", 32'(n), 32'd33);
    check("done stall", 32'(ex_stall), 32'd0);
    step();
    check("mult bubble wb", 32'(o_wb), 32'd0);
    check("mult bubble m", 32'(o_m), 32'd0);
    drive(2'b10, 3'b000, 4'b1100, 32'h54, 32'd0, 32'd0, 32'h10, 5'd0, 5'd12);
    step();
    check("mfhi", o_res, 32'hFFFFFFFF);
    check("mfhi wb", 32'(o_wb), 32'd2);
    drive(2'b10, 3'b000, 4'b1100, 32'h58, 32'd0, 32'd0, 32'h12, 5'd0, 5'd13);
    step();
    check("mflo", o_res, 32'hFFFFFFEB);

    // reset in the middle of BUSY
    drive(2'b10, 3'b000, 4'b1100, 32'h5C, 32'd100, 32'd3, 32'h18, 5'd2, 5'd3);
    repeat (10) step();
    check("busy stall", 32'(ex_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("reset drops stall", 32'(ex_stall), 32'd0);
    drive(2'b10, 3'b000, 4'b1100, 32'h60, 32'd0, 32'd0, 32'h10, 5'd0, 5'd12);
    #2 rst_n = 1'b1;
    step();
    check("mfhi after reset", o_res, 32'd0);
    drive(2'b10, 3'b000, 4'b1100, 32'h64, 32'd0, 32'd0, 32'h12, 5'd0, 5'd13);
    step();
    check("mflo after reset", o_res, 32'd0);
`else
    // mult funct without the multiplier: result 0, controls pass, no stall
    drive(2'b10, 3'b010, 4'b1100, 32'h50, 32'hFFFFFFFD, 32'd7, 32'h18, 5'd2, 5'd3);
    #1 check("no-mult stall", 32'(ex_stall), 32'd0);
    step();
    check("no-mult res", o_res, 32'd0);
    check("no-mult wb", 32'(o_wb), 32'd2);
    check("no-mult m", 32'(o_m), 32'd2);
    drive(2'b10, 3'b000, 4'b1100, 32'h54, 32'd0, 32'd0, 32'h10, 5'd0, 5'd12);
    step();
    check("no-mult mfhi", o_res, 32'd0);
`endif

    // asynchronous reset mid-run with live outputs
    drive(2'b11, 3'b010, 4'b0001, 32'h300, 32'h44, 32'h55, 32'h4, 5'd6, 5'd7);
    step();
    check("pre-reset res", o_res, 32'h48);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrun reset");
    #2 rst_n = 1'b1;
    step();
    check("post-reset res", o_res, 32'h48);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
